// File: rtl/upload_arbiter.sv
// upload_arbiter: round-robin frame arbiter that merges NUM_CH byte streams into one output stream.
// Define UPLOAD_ARB_TIMEOUT_EN to add a stall watchdog that force-releases a grant and masks the channel.
module upload_arbiter #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         in_req,
  input  logic [NUM_CH*8-1:0]       in_data,
  input  logic [NUM_CH*8-1:0]       in_source,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  output logic                      out_req,
  output logic [7:0]                out_data,
  output logic [7:0]                out_source,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] grant_ch,
  output logic                      busy,
  output logic                      timeout_pulse
);

  localparam int unsigned CW = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_grant;
  logic [CW-1:0]     w_grant_nxt;
  logic [CW-1:0]     r_last;
  logic [CW-1:0]     w_last_nxt;
  logic [CW-1:0]     w_pick;
  logic [7:0]        r_src;
  logic [7:0]        w_src_nxt;
  logic [NUM_CH-1:0] w_elig;
  logic              w_found;
  logic              w_timeout;
  logic              w_to_hit;
  logic              w_sel_req;
  logic              w_sel_valid;
  logic [7:0]        w_sel_data;
  logic [7:0]        w_sel_src;

  // Granted channel's lanes
  assign w_sel_req   = in_req[r_grant];
  assign w_sel_valid = in_valid[r_grant];
  assign w_sel_data  = in_data[{r_grant, 3'b000} +: 8];
  assign w_sel_src   = in_source[{r_grant, 3'b000} +: 8];

  // Round-robin search starting one past the last granted channel
  always_comb begin : rr_pick
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      if (!w_found && w_elig[CW'((32'(r_last) + i) % NUM_CH)]) begin
        w_found = 1'b1;
        w_pick  = CW'((32'(r_last) + i) % NUM_CH);
      end
    end
  end

`ifdef UPLOAD_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0]     r_idle_cnt;
  logic [NUM_CH-1:0] r_mask;
  logic              r_timeout_pulse;
  logic              w_xfer;

  assign w_xfer        = (r_state == S_GRANT) && w_sel_valid && out_ready;
  assign w_elig        = in_req & ~r_mask;
  assign w_to_hit      = (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1)) && !w_xfer;
  assign timeout_pulse = r_timeout_pulse;

  // Watchdog: counts stalled grant cycles; a mask holds until the channel drops its request
  always_ff @(posedge clk) begin : watchdog_reg
    if (!rst_n) begin
      r_idle_cnt      <= '0;
      r_mask          <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_timeout;
      r_mask          <= (r_mask & in_req) | (w_timeout ? (NUM_CH'(1) << r_grant) : '0);
      if (r_state != S_GRANT || w_xfer || w_timeout) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + TW'(1);
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_elig        = in_req;
  assign w_to_hit      = 1'b0;
  assign timeout_pulse = 1'b0;
  assign w_unused_cfg  = w_timeout | (TIMEOUT_CYCLES == 32'd0);
`endif

  // Next-state and combinational passthrough
  always_comb begin : fsm_comb
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_src_nxt   = r_src;
    w_timeout   = 1'b0;
    out_req     = 1'b0;
    out_data    = 8'h00;
    out_valid   = 1'b0;
    out_source  = r_src;
    in_ready    = '0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_grant_nxt = w_pick;
        end
      end
      S_GRANT: begin
        busy              = 1'b1;
        out_req           = w_sel_req;
        out_data          = w_sel_data;
        out_source        = w_sel_src;
        out_valid         = w_sel_valid & w_sel_req;
        in_ready[r_grant] = out_ready;
        w_src_nxt         = w_sel_src;
        if (!w_sel_req) begin
          w_state_nxt = S_GAP;
          w_last_nxt  = r_grant;
        end else if (w_to_hit) begin
          w_state_nxt = S_GAP;
          w_last_nxt  = r_grant;
          w_timeout   = 1'b1;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin : fsm_reg
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= CW'(NUM_CH - 1);
      r_src   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_src   <= w_src_nxt;
    end
  end

  assign grant_ch = r_grant;

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed testbench for upload_arbiter (NUM_CH=4, TIMEOUT_CYCLES=16).
module tb_upload_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_req;
  logic [31:0] in_data;
  logic [31:0] in_source;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        out_req;
  logic [7:0]  out_data;
  logic [7:0]  out_source;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant_ch;
  logic        busy;
  logic        timeout_pulse;

  int checks;
  int errors;

  upload_arbiter #(
    .NUM_CH         (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_req        (in_req),
    .in_data       (in_data),
    .in_source     (in_source),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_req       (out_req),
    .out_data      (out_data),
    .out_source    (out_source),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .grant_ch      (grant_ch),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n     = 1'b0;
    in_req    = 4'b1111;
    in_valid  = 4'b0000;
    in_data   = 32'h0;
    in_source = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (out_req !== 1'b0 || in_ready !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_cycle%0d: out_req=%b in_ready=%b busy=%b, required 0 0000 0", i, out_req, in_ready, busy);
      end
    end
    checks++;
    if (grant_ch !== 2'd0 || out_source !== 8'h00 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: grant_ch=%0d out_source=%h timeout_pulse=%b, required 0 00 0", grant_ch, out_source, timeout_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || grant_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant: busy=%b grant_ch=%0d, required 1 0", busy, grant_ch);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ch;
    logic [3:0] oh;
    logic [7:0] b_exp;
    logic [7:0] s_exp;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      ch    = 2'(k % 4);
      oh    = 4'b0001 << ch;
      s_exp = 8'h10 + 8'(ch);
      for (int b = 0; b < 6; b++) begin
        b_exp   = 8'(8'hC0 + k * 8 + b);
        in_data = {4{8'h5A}};
        in_data[8 * int'(ch) +: 8] = b_exp;
        #1;
        checks++;
        if (busy !== 1'b1 || grant_ch !== ch || out_req !== 1'b1 || out_valid !== 1'b1 ||
            out_data !== b_exp || out_source !== s_exp || in_ready !== oh) begin
          errors++;
          $display("FAIL rr_frame%0d_byte%0d: busy=%b grant_ch=%0d out_data=%h out_source=%h in_ready=%b, required 1 %0d %h %h %b",
                   k, b, busy, grant_ch, out_data, out_source, in_ready, ch, b_exp, s_exp, oh);
        end
        @(negedge clk);
      end
      // Request drops while the byte is still valid: must not be forwarded
      in_req = 4'b1111 & ~oh;
      #1;
      checks++;
      if (busy !== 1'b1 || out_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== oh) begin
        errors++;
        $display("FAIL rr_drop%0d: busy=%b out_req=%b out_valid=%b in_ready=%b, required 1 0 0 %b",
                 k, busy, out_req, out_valid, in_ready, oh);
      end
      @(negedge clk);
      in_req = (k < 4) ? 4'b1111 : 4'b0000;
      #1;
      checks++;
      if (busy !== 1'b0 || out_req !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
          in_ready !== 4'b0000 || out_source !== s_exp) begin
        errors++;
        $display("FAIL rr_gap%0d: busy=%b out_req=%b out_valid=%b out_data=%h in_ready=%b out_source=%h, required 0 0 0 00 0000 %h",
                 k, busy, out_req, out_valid, out_data, in_ready, out_source, s_exp);
      end
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b0 || out_req !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle%0d: busy=%b out_req=%b, required 0 0", k, busy, out_req);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_passthrough();
    in_req   = 4'b0100;
    in_valid = 4'b0000;
    @(negedge clk);
    in_data   = {8'h11, 8'hAA, 8'h22, 8'h33};
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (grant_ch !== 2'd2 || out_req !== 1'b1 || out_data !== 8'hAA || out_valid !== 1'b1 ||
        in_ready !== 4'b0100 || out_source !== 8'h12) begin
      errors++;
      $display("FAIL pass_byte: grant_ch=%0d out_req=%b out_data=%h out_valid=%b in_ready=%b out_source=%h, required 2 1 aa 1 0100 12",
               grant_ch, out_req, out_data, out_valid, in_ready, out_source);
    end
    in_valid = 4'b0000;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_req !== 1'b1 || out_data !== 8'hAA) begin
      errors++;
      $display("FAIL pass_novalid: out_valid=%b out_req=%b out_data=%h, required 0 1 aa", out_valid, out_req, out_data);
    end
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_noready: in_ready=%b out_valid=%b, required 0000 1", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int   idx;
    int   xfers;
    logic rdy;
    idx   = 0;
    xfers = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy       = !(c >= 2 && c < 7);
      out_ready = rdy;
      in_valid  = 4'b0100;
      in_data[23:16] = 8'(8'hD0 + idx);
      #1;
      checks++;
      if (busy !== 1'b1 || grant_ch !== 2'd2 || in_ready !== {1'b0, rdy, 2'b00} ||
          out_valid !== 1'b1 || out_data !== 8'(8'hD0 + idx)) begin
        errors++;
        $display("FAIL bp_cycle%0d: busy=%b grant_ch=%0d in_ready=%b out_valid=%b out_data=%h, required 1 2 %b 1 %h",
                 c, busy, grant_ch, in_ready, out_valid, out_data, {1'b0, rdy, 2'b00}, 8'(8'hD0 + idx));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) xfers++;
      if (in_ready[2] === 1'b1) idx++;
    end
    checks++;
    if (xfers != 5) begin
      errors++;
      $display("FAIL bp_xfer_count: transfers=%0d, required 5", xfers);
    end
    @(negedge clk);
    in_req    = 4'b0000;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: busy=%b out_req=%b, required 0 0", busy, out_req);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    in_req = 4'b0010;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || grant_ch !== 2'd1) begin
      errors++;
      $display("FAIL sim_grant1: busy=%b grant_ch=%0d, required 1 1", busy, grant_ch);
    end
    @(negedge clk);
    in_req = 4'b1000;
    #1;
    checks++;
    if (busy !== 1'b1 || out_req !== 1'b0) begin
      errors++;
      $display("FAIL sim_drop: busy=%b out_req=%b, required 1 0", busy, out_req);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_req !== 1'b0) begin
      errors++;
      $display("FAIL sim_gap: busy=%b out_req=%b, required 0 0", busy, out_req);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || out_req !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle: busy=%b out_req=%b, required 0 0", busy, out_req);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || grant_ch !== 2'd3) begin
      errors++;
      $display("FAIL sim_grant3: busy=%b grant_ch=%0d, required 1 3", busy, grant_ch);
    end
  endtask

  task automatic test_reset_midframe();
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    in_data[31:24] = 8'h77;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h77 || out_source !== 8'h13) begin
      errors++;
      $display("FAIL rstmid_before: out_valid=%b out_data=%h out_source=%h, required 1 77 13", out_valid, out_data, out_source);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (out_req !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 ||
        in_ready !== 4'b0000 || out_source !== 8'h00 || grant_ch !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_after: out_req=%b out_valid=%b out_data=%h busy=%b in_ready=%b out_source=%h grant_ch=%0d, required 0 0 00 0 0000 00 0",
               out_req, out_valid, out_data, busy, in_ready, out_source, grant_ch);
    end
    in_req   = 4'b0000;
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    int busy_cnt;
    int pulse_cnt;
    int pulse_at;
    busy_cnt  = 0;
    pulse_cnt = 0;
    pulse_at  = -1;
    @(negedge clk);
    in_req    = 4'b0001;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b1) busy_cnt++;
      if (timeout_pulse === 1'b1) begin
        pulse_cnt++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
`ifdef UPLOAD_ARB_TIMEOUT_EN
    checks++;
    if (busy_cnt != 16) begin
      errors++;
      $display("FAIL to_grant_len: busy_cycles=%0d, required 16", busy_cnt);
    end
    checks++;
    if (pulse_cnt != 1 || pulse_at != 16) begin
      errors++;
      $display("FAIL to_pulse: pulses=%0d first_at=%0d, required 1 16", pulse_cnt, pulse_at);
    end
    @(negedge clk);
    in_req = 4'b0000;
    @(negedge clk);
    in_req = 4'b0001;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || grant_ch !== 2'd0) begin
      errors++;
      $display("FAIL to_regrant: busy=%b grant_ch=%0d, required 1 0", busy, grant_ch);
    end
`else
    checks++;
    if (busy_cnt != 40 || pulse_cnt != 0) begin
      errors++;
      $display("FAIL no_timeout: busy_cycles=%0d pulses=%0d, required 40 0", busy_cnt, pulse_cnt);
    end
`endif
    @(negedge clk);
    in_req = 4'b0000;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL to_final_idle: busy=%b timeout_pulse=%b, required 0 0", busy, timeout_pulse);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_passthrough();
    test_backpressure();
    test_simultaneous();
    test_reset_midframe();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
